// File: rtl/vga_cmd_pkg.sv
// Shared constants for the UART pattern command block: ASCII codes, TX FSM
// encoding and small hex/ASCII conversion helpers.
package vga_cmd_pkg;

    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_SEND      = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_e;

    // Returns {is_hex_digit, value}; either letter case is accepted.
    function automatic logic [4:0] ascii_to_hex(input logic [7:0] b);
        logic [4:0] r;
        r = 5'd0;
        if (b >= 8'h30 && b <= 8'h39) begin
            r = {1'b1, 4'(b - 8'h30)};
        end else if (b >= 8'h41 && b <= 8'h46) begin
            r = {1'b1, 4'(b - 8'h37)};
        end else if (b >= 8'h61 && b <= 8'h66) begin
            r = {1'b1, 4'(b - 8'h57)};
        end
        return r;
    endfunction

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'd0, v}) : (8'h37 + {4'd0, v});
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Small synchronous FIFO for response bytes; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Push,
    input  logic [WIDTH-1:0] i_Data,
    input  logic             i_Pop,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Full,
    output logic             o_Empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign o_Full  = (count_q == CW'(DEPTH));
    assign o_Empty = (count_q == '0);
    assign o_Data  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = i_Pop && !o_Empty;
        do_push  = i_Push && (!o_Full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = i_Data;
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_pattern_cmd.sv
// Decodes single-byte UART commands into a test-pattern index and echoes the
// new index (or '?') back through a 2-entry response FIFO and a TX handshake FSM.
module uart_pattern_cmd
    import vga_cmd_pkg::*;
#(
    parameter int NUM_PATTERNS = 8,
    parameter int IDX_WIDTH    = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_RX_DV,
    input  logic [7:0]           i_RX_Byte,
    input  logic                 i_TX_Active,
    input  logic                 i_TX_Done,
    output logic                 o_TX_DV,
    output logic [7:0]           o_TX_Byte,
    output logic [IDX_WIDTH-1:0] o_Pattern,
    output logic                 o_Pattern_Change,
    output logic [7:0]           o_Err_Count,
    output logic                 o_Overrun
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PATTERNS - 1);

    logic [IDX_WIDTH-1:0] pattern_q, pattern_d;
    logic                 change_q, change_d;
    logic [7:0]           err_count_q, err_count_d;
    logic                 overrun_q, overrun_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    tx_state_e            state_q, state_d;

    logic                 cmd_accept, cmd_reject;
    logic [IDX_WIDTH-1:0] new_idx;
    logic [4:0]           hex_dec;
    logic                 resp_push;
    logic [7:0]           resp_byte;
    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [7:0]           fifo_head;

    // Command decode: a response is pushed in the same edge the pattern updates,
    // so the FSM can see it one cycle later.
    always_comb begin
        cmd_accept = 1'b0;
        cmd_reject = 1'b0;
        new_idx    = pattern_q;
        hex_dec    = ascii_to_hex(i_RX_Byte);
        if (i_RX_DV) begin
            if (hex_dec[4]) begin
                if (int'({28'd0, hex_dec[3:0]}) < NUM_PATTERNS) begin
                    cmd_accept = 1'b1;
                    new_idx    = IDX_WIDTH'(hex_dec[3:0]);
                end else begin
                    cmd_reject = 1'b1;
                end
            end else if (i_RX_Byte == ASCII_PLUS) begin
                cmd_accept = 1'b1;
                new_idx    = (pattern_q == LAST_IDX) ? '0 : pattern_q + IDX_WIDTH'(1);
            end else if (i_RX_Byte == ASCII_MINUS) begin
                cmd_accept = 1'b1;
                new_idx    = (pattern_q == '0) ? LAST_IDX : pattern_q - IDX_WIDTH'(1);
            end else if (i_RX_Byte != ASCII_CR && i_RX_Byte != ASCII_LF) begin
                cmd_reject = 1'b1;
            end
        end
    end

    always_comb begin
        resp_push   = cmd_accept || cmd_reject;
        resp_byte   = cmd_accept ? hex_to_ascii(4'(new_idx)) : ASCII_QMARK;
        pattern_d   = cmd_accept ? new_idx : pattern_q;
        change_d    = cmd_accept;
        err_count_d = (cmd_reject && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
        overrun_d   = overrun_q || (resp_push && fifo_full && !fifo_pop);
    end

    resp_fifo #(
        .WIDTH(8),
        .DEPTH(2)
    ) u_resp_fifo (
        .i_Clk  (i_Clk),
        .i_Reset(i_Reset),
        .i_Push (resp_push),
        .i_Data (resp_byte),
        .i_Pop  (fifo_pop),
        .o_Data (fifo_head),
        .o_Full (fifo_full),
        .o_Empty(fifo_empty)
    );

    // The head is captured on entry to SEND so o_TX_Byte holds afterwards.
    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        fifo_pop  = 1'b0;
        o_TX_DV   = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty && !i_TX_Active) begin
                    state_d   = TX_SEND;
                    tx_byte_d = fifo_head;
                end
            end
            TX_SEND: begin
                o_TX_DV  = 1'b1;
                fifo_pop = 1'b1;
                state_d  = TX_WAIT_DONE;
            end
            TX_WAIT_DONE: begin
                if (i_TX_Done) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            pattern_q   <= '0;
            change_q    <= 1'b0;
            err_count_q <= 8'd0;
            overrun_q   <= 1'b0;
            tx_byte_q   <= 8'd0;
            state_q     <= TX_IDLE;
        end else begin
            pattern_q   <= pattern_d;
            change_q    <= change_d;
            err_count_q <= err_count_d;
            overrun_q   <= overrun_d;
            tx_byte_q   <= tx_byte_d;
            state_q     <= state_d;
        end
    end

    assign o_Pattern        = pattern_q;
    assign o_Pattern_Change = change_q;
    assign o_Err_Count      = err_count_q;
    assign o_Overrun        = overrun_q;
    assign o_TX_Byte        = tx_byte_q;

endmodule

// File: doc/uart_pattern_cmd.md
UART_PATTERN_CMD -- requirements
Module: uart_pattern_cmd

Interface
REQ-001 SHALL have parameter NUM_PATTERNS, default 8, meaning the number of valid pattern indices (0..NUM_PATTERNS-1, legal range 1..16).
REQ-002 SHALL have parameter IDX_WIDTH, default 4, meaning the width of the pattern index.
REQ-003 i_Clk  input  1  sole clock; all logic on rising edge.
REQ-004 i_Reset  input  1  asynchronous, active-high reset.
REQ-005 i_RX_DV  input  1  one-cycle pulse: byte received from UART RX.
REQ-006 i_RX_Byte  input  8  received byte; sampled only when i_RX_DV=1.
REQ-007 i_TX_Active  input  1  UART TX busy.
REQ-008 i_TX_Done  input  1  one-cycle pulse: UART TX finished a byte.
REQ-009 o_TX_DV  output  1  one-cycle request to UART TX.
REQ-010 o_TX_Byte  output  8  response byte; valid when o_TX_DV=1.
REQ-011 o_Pattern  output  IDX_WIDTH  current test-pattern index to the pattern generator.
REQ-012 o_Pattern_Change  output  1  one-cycle pulse on every accepted command.
REQ-013 o_Err_Count  output  8  count of rejected bytes, saturating.
REQ-014 o_Overrun  output  1  sticky flag: a response was dropped.

Function
REQ-015 SHALL decode ASCII '0'-'9', 'A'-'F', 'a'-'f' as the hex value d; accept it if d < NUM_PATTERNS and set o_Pattern=d; otherwise reject.
REQ-016 SHALL treat '+' as o_Pattern+1, wrapping NUM_PATTERNS-1 -> 0.
REQ-017 SHALL treat '-' as o_Pattern-1, wrapping 0 -> NUM_PATTERNS-1.
REQ-018 SHALL silently ignore 0x0D and 0x0A: no pattern change, no response, no error count.
REQ-019 SHALL reject every other byte value.
REQ-020 SHALL apply commands regardless of TX state; i_RX_DV in cycle N -> o_Pattern and o_Pattern_Change valid in cycle N+1.
REQ-021 SHALL pulse o_Pattern_Change for every accepted command, including one that leaves the value unchanged.
REQ-022 SHALL queue a response in cycle N+1: for an accepted command, the uppercase ASCII hex of the new index ('0'-'9', 'A'-'F'); for a rejected byte, '?' (0x3F).
REQ-023 SHALL increment o_Err_Count on each rejected byte and hold it at 255.
REQ-024 SHALL buffer responses in a 2-entry FIFO, delivered in order.
REQ-025 FIFO full with no pop in the same cycle: SHALL drop the new response and set o_Overrun=1 (cleared only by reset). Full with a simultaneous pop: SHALL accept the push.
REQ-026 SHALL implement the TX FSM with states IDLE, SEND, WAIT_DONE.
- IDLE -> SEND when the FIFO is non-empty and i_TX_Active=0.
- SEND: o_TX_DV=1 for exactly one cycle, o_TX_Byte = FIFO head, pop the FIFO; then -> WAIT_DONE.
- WAIT_DONE -> IDLE on i_TX_Done=1.
REQ-027 SHALL make o_TX_DV earliest in cycle N+2 for a command pulse in cycle N.
REQ-028 SHALL keep o_TX_Byte stable at its last value outside SEND.
REQ-029 SHALL ignore i_TX_Done outside WAIT_DONE.

Reset
REQ-030 SHALL drive the following on i_Reset=1, immediately and independent of clock: o_Pattern=0, o_Pattern_Change=0, o_TX_DV=0, o_TX_Byte=0x00, o_Err_Count=0, o_Overrun=0, FIFO empty, FSM=IDLE.
REQ-031 Reset asserted mid-transmission: SHALL abandon the pending response with no replay after release.
REQ-032 SHALL ignore an i_RX_DV coincident with reset.

Structure
REQ-033 SHALL place the following in shared package vga_cmd_pkg: the ASCII constants ('+', '-', '?', CR, LF) and the FSM state encoding.
REQ-034 SHALL implement the 2-entry response buffer as sub-module resp_fifo (width 8, depth 2, push/pop/full/empty).

Verification
REQ-035 Reset, then RX '5' -> next cycle o_Pattern=5 with one o_Pattern_Change pulse; o_TX_DV with byte 0x35; complete after i_TX_Done.
REQ-036 o_Pattern=7 (NUM_PATTERNS=8), RX '+' -> o_Pattern=0, TX '0'; then RX '-' -> o_Pattern=7, TX '7'.
REQ-037 RX '9' (out of range), 'x', then 0x0D -> o_Pattern unchanged; o_Err_Count=2; TX '?', '?' only; nothing sent for CR.
REQ-038 i_TX_Active held high, RX '1','2','3' back-to-back -> o_Pattern=3; o_Overrun=1; after TX frees, only '1','2' are sent.
REQ-039 300 invalid bytes -> o_Err_Count=255 and holds.
REQ-040 Assert i_Reset during WAIT_DONE with one FIFO entry pending -> all outputs at reset values; no o_TX_DV after release.
